dmem_sramlike_bridge: RTL
=========================

// Module: dmem_sramlike_bridge
// PURPOSE
// - Sits between the MEM stage of the 5-stage MIPS datapath and the SRAM-like data bus.
// - Turns the single-cycle data-SRAM request (en/wen/addr/wdata) into a two-phase req/addr_ok/data_ok transaction.
// - Raises stallreq_from_mem until load data is available, then holds that data while the pipeline stays stalled by other causes.
// - Drains a transaction that is already in flight when an exception flush hits MEM.
// PARAMETERS
// - ADDR_W  32  address width
// - DATA_W  32  data width
// PORTS
// - clk               in   1       single clock, rising edge
// - rst               in   1       asynchronous, active-high reset
// - cpu_en            in   1       MEM-stage memory access valid (memenM)
// - cpu_wen           in   4       byte write enables (memwriteM); nonzero => store
// - cpu_size          in   2       0=byte, 1=half, 2=word
// - cpu_addr          in   ADDR_W  byte address (aluoutM)
// - cpu_wdata         in   DATA_W  store data, already lane-aligned (writedata2M)
// - cpu_flush         in   1       MEM-stage flush (exception/eret, flushM)
// - cpu_longest_stall in   1       OR of all pipeline stall sources except this block
// - cpu_rdata         out  DATA_W  load data to the load_mux (readdataM)
// - stallreq_from_mem out  1       pipeline stall request
// - data_req          out  1       bus request
// - data_wr           out  1       1 = write
// - data_size         out  2       latched cpu_size
// - data_addr         out  ADDR_W  latched address
// - data_wdata        out  DATA_W  latched write data
// - data_addr_ok      in   1       address/request accepted
// - data_data_ok      in   1       read data valid / write done
// - data_rdata        in   DATA_W  bus read data
// BEHAVIOUR
// - FSM states:
//   - IDLE:  when cpu_en && !cpu_flush, latch wr=|cpu_wen, size, addr, wdata; go to ADDR.
//   - ADDR:  data_req=1, held with stable addr/size/wdata/wr until data_addr_ok; then go to DATA.
//   - DATA:  wait for data_data_ok. On data_data_ok, capture data_rdata into rbuf.
//            Then go to DONE if cpu_longest_stall && !discard, else go to IDLE.
//   - DONE:  hold rbuf; when !cpu_longest_stall, go to IDLE.
// - data_addr_ok is sampled only in ADDR; data_data_ok is sampled only in DATA. Both are ignored elsewhere.
// - stallreq_from_mem = (cpu_en && state!=DONE && !(state==DATA && data_data_ok && !discard)) || discard.
//   - Minimum stall for an access: IDLE(1) + ADDR(>=1) + DATA(>=1, released combinationally on data_ok).
// - cpu_rdata = (state==DATA && data_data_ok) ? data_rdata : rbuf. This is a zero-cycle bypass on the completion cycle.
// - Flush:
//   - In IDLE: no request is issued.
//   - In ADDR or DATA: set discard. The bus transaction still completes (req stays high until addr_ok; data_ok is still awaited).
//   - Data is not written to rbuf while discard=1. Return to IDLE and clear discard on data_ok.
//   - While discard=1, stallreq_from_mem=1 so that no overlapping request is issued.
//   - In DONE: go to IDLE and drop the held data.
// - A new cpu_en in the cycle after a completion is a new instruction and starts a new IDLE->ADDR sequence.
// - Reset (asynchronous, any state, including mid-transaction):
//   - state=IDLE, discard=0, rbuf=0, latched addr/wdata=0, wr=0, size=0.
//   - All outputs: data_req=0, stallreq_from_mem=0, cpu_rdata=0.
//   - A bus reply arriving after reset is ignored because the FSM is in IDLE.
// - Write completion follows the same path; cpu_rdata is don't-care for stores.
// STRUCTURE
// - FSM state encodings (IDLE=2'd0, ADDR=2'd1, DATA=2'd2, DONE=2'd3) go in the shared defines header next to the ALU opcodes.
// - No sub-module. One FSM, one request-latch register group, and one rbuf register; the 120-200 RTL lines stay flat.
// - The instruction-side twin reuses this module with cpu_wen=0 and cpu_size=2.
// TESTING
// - Load, no other stall:
//   - addr=0x80, addr_ok at cycle 2, data_ok with 0xDEADBEEF at cycle 4.
//   - Required: stall high for cycles 1-3, low at cycle 4; cpu_rdata=0xDEADBEEF at cycle 4; state IDLE at cycle 5.
// - Load completing while cpu_longest_stall=1 for 3 more cycles:
//   - Required: state DONE; stall low; cpu_rdata stays 0xDEADBEEF until longest_stall falls; no second data_req.
// - Store, wen=4'b0011, size=1, addr=0x102:
//   - Required: data_wr=1, data_size=1, data_addr=0x102, data_wdata stable until addr_ok; stall drops on data_ok.
// - Flush in DATA:
//   - Required: stall stays high until data_ok; rbuf keeps its old value (0); state goes to IDLE.
//   - A following cpu_en issues a fresh req only after that.
// - addr_ok delayed 5 cycles:
//   - Required: data_req high with constant addr for all 5 cycles; a spurious data_ok during ADDR is ignored.
// - rst asserted in DATA:
//   - Required: outputs are 0 the same cycle, state is IDLE, and a later data_ok causes no change.

Source files
------------

// File: rtl/dmem_sramlike_bridge_pkg.sv
// Shared definitions for the data-memory SRAM-like bridge: FSM state
// encodings used by the bridge and by any bench that observes its state.
package dmem_sramlike_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // no transaction; accept a new MEM-stage access
      ST_ADDR = 2'd1,   // request on the bus, waiting for addr_ok
      ST_DATA = 2'd2,   // address accepted, waiting for data_ok
      ST_DONE = 2'd3    // load complete, holding data while pipeline stalls
   } state_e;

endpackage

// File: rtl/dmem_sramlike_bridge.sv
// Bridge between the MEM stage (single-cycle en/wen/addr/wdata request) and
// an SRAM-like req/addr_ok/data_ok bus. Stalls the pipeline until a load's
// data arrives, holds it while other stall sources keep the pipeline frozen,
// and drains an in-flight transaction when MEM is flushed.
//
// Bus handshake: data_req stays high with constant wr/size/addr/wdata until
// the cycle in which data_addr_ok is seen high (sampled only in ADDR); the
// reply is the first cycle afterwards with data_data_ok high (sampled only in
// DATA). Both responses are ignored in every other state.
module dmem_sramlike_bridge
   import dmem_sramlike_bridge_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_en,
   input  logic [3:0]        cpu_wen,
   input  logic [1:0]        cpu_size,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_flush,
   input  logic              cpu_longest_stall,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              stallreq_from_mem,
   output logic              data_req,
   output logic              data_wr,
   output logic [1:0]        data_size,
   output logic [ADDR_W-1:0] data_addr,
   output logic [DATA_W-1:0] data_wdata,
   input  logic              data_addr_ok,
   input  logic              data_data_ok,
   input  logic [DATA_W-1:0] data_rdata
);

   state_e            state_q, state_d;
   logic              discard_q, discard_d;
   logic              req_q, req_d;
   logic              wr_q, wr_d;
   logic [1:0]        size_q, size_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rbuf_q, rbuf_d;

   logic              data_ok_hit;

   // A reply only counts while the FSM is actually waiting for it.
   assign data_ok_hit = (state_q == ST_DATA) && data_data_ok;

   // Next-state, request latch and read-buffer update.
   always_comb begin
      state_d   = state_q;
      discard_d = discard_q;
      wr_d      = wr_q;
      size_d    = size_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rbuf_d    = rbuf_q;
      case (state_q)
         ST_IDLE: begin
            if (cpu_en && !cpu_flush) begin
               wr_d    = |cpu_wen;
               size_d  = cpu_size;
               addr_d  = cpu_addr;
               wdata_d = cpu_wdata;
               state_d = ST_ADDR;
            end
         end
         ST_ADDR: begin
            // A flush cannot retract a request already on the bus; remember
            // to throw the reply away instead.
            if (cpu_flush) discard_d = 1'b1;
            if (data_addr_ok) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (data_data_ok) begin
               if (!discard_q) rbuf_d = data_rdata;
               discard_d = 1'b0;
               if (cpu_longest_stall && !discard_q && !cpu_flush)
                  state_d = ST_DONE;
               else
                  state_d = ST_IDLE;
            end else if (cpu_flush) begin
               discard_d = 1'b1;
            end
         end
         ST_DONE: begin
            if (cpu_flush || !cpu_longest_stall) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Bus request is registered: high for exactly the cycles spent in ADDR.
   assign req_d = (state_d == ST_ADDR);

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         discard_q <= 1'b0;
         req_q     <= 1'b0;
         wr_q      <= 1'b0;
         size_q    <= 2'd0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rbuf_q    <= '0;
      end else begin
         state_q   <= state_d;
         discard_q <= discard_d;
         req_q     <= req_d;
         wr_q      <= wr_d;
         size_q    <= size_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rbuf_q    <= rbuf_d;
      end
   end

   assign data_req   = req_q;
   assign data_wr    = wr_q;
   assign data_size  = size_q;
   assign data_addr  = addr_q;
   assign data_wdata = wdata_q;

   // Completion cycle bypasses the bus data straight to the load mux.
   assign cpu_rdata = data_ok_hit ? data_rdata : rbuf_q;

   // Stall until the reply arrives; a pending discard blocks new accesses.
   // Reset forces the stall low even while cpu_en is still asserted.
   assign stallreq_from_mem = !rst &&
      ((cpu_en && (state_q != ST_DONE) && !(data_ok_hit && !discard_q)) ||
       discard_q);

endmodule
